// File: rtl/wait_mem_arbiter_pkg.sv
// Shared types for the wait/memory arbiter: the arbiter state encoding and a
// helper that says whether the wait-timeout counter should be running.
package wait_mem_arbiter_pkg;

  typedef enum logic [2:0] {
    ARB_CPU         = 3'd0,
    ARB_HOST_IDLE   = 3'd1,
    ARB_HOST_ACCESS = 3'd2,
    ARB_ACK         = 3'd3,
    ARB_RELEASE     = 3'd4
  } arb_state_t;

  // The timeout counter runs for the whole host window, including an access
  // in flight; it is frozen while the CPU owns the port or is being released.
  function automatic logic in_wait_window(input arb_state_t state);
    return (state == ARB_HOST_IDLE) || (state == ARB_HOST_ACCESS) || (state == ARB_ACK);
  endfunction

endpackage

// File: rtl/wait_mem_arbiter_timeout.sv
// Saturating wait-timeout counter. "expired" flags that the configured number
// of host-window cycles has elapsed; a cfg of zero disables the timeout.
module wait_timeout_counter
  #(parameter int TIMEOUT_BITS = 16)
  (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    enable,
    input  logic [TIMEOUT_BITS-1:0] cfg,
    output logic                    expired
  );

  logic [TIMEOUT_BITS-1:0] count;

  // Count up while enabled, holding at all-ones instead of wrapping.
  always_ff @(posedge clock) begin
    // NOTE: state registers use non-blocking (<=) so every flop samples the
    // pre-edge values; blocking here would create order-dependent races.
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + TIMEOUT_BITS'(1);
    end
  end

  // Expire one count early so the release lands exactly cfg cycles into the wait.
  always_comb begin
    expired = (cfg != '0) && (count >= (cfg - TIMEOUT_BITS'(1)));
  end

endmodule

// File: rtl/wait_mem_arbiter.sv
// Data-memory port arbiter between processor stage 2 and an external host.
// The CPU owns the port except while stalled on OP_WAIT; during that window
// the host may perform single accesses, and the window closes with a
// one-cycle wait_release pulse on host_done or timeout.
module wait_mem_arbiter
  import wait_mem_arbiter_pkg::*;
  #(
    parameter int ADDR_SIZE    = 18,
    parameter int WORD_SIZE    = 18,
    parameter int TIMEOUT_BITS = 16
  )
  (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [ADDR_SIZE-1:0]    cpu_addr,
    input  logic                    cpu_we,
    input  logic [WORD_SIZE-1:0]    cpu_wdata,
    input  logic                    cpu_waiting,
    output logic                    wait_release,
    input  logic [TIMEOUT_BITS-1:0] timeout_cfg,
    input  logic                    host_req,
    input  logic                    host_we,
    input  logic [ADDR_SIZE-1:0]    host_addr,
    input  logic [WORD_SIZE-1:0]    host_wdata,
    input  logic                    host_done,
    output logic                    host_ack,
    output logic [WORD_SIZE-1:0]    host_rdata,
    output logic                    host_granted,
    output logic [ADDR_SIZE-1:0]    mem_addr,
    output logic                    mem_we,
    output logic [WORD_SIZE-1:0]    mem_din,
    input  logic [WORD_SIZE-1:0]    mem_dout
  );

  arb_state_t state, state_next;
  logic       timeout_expired;

  wait_timeout_counter #(.TIMEOUT_BITS(TIMEOUT_BITS)) u_timeout (
    .clock   (clock),
    .reset   (reset),
    .clear   (state == ARB_CPU),
    .enable  (in_wait_window(state)),
    .cfg     (timeout_cfg),
    .expired (timeout_expired)
  );

  // Arbiter state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ARB_CPU;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic, Moore outputs and the memory port mux.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    state_next   = state;
    wait_release = 1'b0;
    host_granted = 1'b0;
    mem_addr     = cpu_addr;
    mem_we       = cpu_we;
    mem_din      = cpu_wdata;

    case (state)
      ARB_CPU: begin
        if (cpu_waiting) state_next = ARB_HOST_IDLE;
      end
      ARB_HOST_IDLE: begin
        host_granted = 1'b1;
        mem_we       = 1'b0;
        if (host_done)            state_next = ARB_RELEASE;
        else if (timeout_expired) state_next = ARB_RELEASE;
        else if (host_req)        state_next = ARB_HOST_ACCESS;
      end
      ARB_HOST_ACCESS: begin
        host_granted = 1'b1;
        mem_addr     = host_addr;
        mem_we       = host_we;
        mem_din      = host_wdata;
        state_next   = ARB_ACK;
      end
      ARB_ACK: begin
        // RAM output for the access is valid now; host_done/timeout wait for IDLE.
        mem_we     = 1'b0;
        state_next = ARB_HOST_IDLE;
      end
      ARB_RELEASE: begin
        wait_release = 1'b1;
        state_next   = ARB_CPU;
      end
      default: state_next = ARB_CPU;
    endcase
  end

  // Register the ack pulse and capture the RAM read data while in ACK.
  always_ff @(posedge clock) begin
    if (reset) begin
      host_ack   <= 1'b0;
      host_rdata <= '0;
    end else begin
      host_ack <= (state == ARB_ACK);
      if (state == ARB_ACK) host_rdata <= mem_dout;
    end
  end

endmodule

// File: tb/tb_wait_mem_arbiter.sv
// Directed self-checking bench for wait_mem_arbiter with a small
// synchronous-read RAM model on the memory port.
module tb_wait_mem_arbiter;

  localparam int AW = 18;
  localparam int WW = 18;
  localparam int TB = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic [AW-1:0] cpu_addr;
  logic          cpu_we;
  logic [WW-1:0] cpu_wdata;
  logic          cpu_waiting;
  logic          wait_release;
  logic [TB-1:0] timeout_cfg;
  logic          host_req;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [WW-1:0] host_wdata;
  logic          host_done;
  logic          host_ack;
  logic [WW-1:0] host_rdata;
  logic          host_granted;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [WW-1:0] mem_din;
  logic [WW-1:0] mem_dout;

  int n_cmp = 0;
  int n_bad = 0;

  wait_mem_arbiter #(.ADDR_SIZE(AW), .WORD_SIZE(WW), .TIMEOUT_BITS(TB)) dut (
    .clock        (clock),
    .reset        (reset),
    .cpu_addr     (cpu_addr),
    .cpu_we       (cpu_we),
    .cpu_wdata    (cpu_wdata),
    .cpu_waiting  (cpu_waiting),
    .wait_release (wait_release),
    .timeout_cfg  (timeout_cfg),
    .host_req     (host_req),
    .host_we      (host_we),
    .host_addr    (host_addr),
    .host_wdata   (host_wdata),
    .host_done    (host_done),
    .host_ack     (host_ack),
    .host_rdata   (host_rdata),
    .host_granted (host_granted),
    .mem_addr     (mem_addr),
    .mem_we       (mem_we),
    .mem_din      (mem_din),
    .mem_dout     (mem_dout)
  );

  always #5 clock = ~clock;

  // Synchronous-read RAM, latency 1, 1K words.
  logic [WW-1:0] ram [0:1023];
  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = '0;
    mem_dout = '0;
  end
  always @(posedge clock) begin
    if (mem_we) ram[mem_addr[9:0]] <= mem_din;
    mem_dout <= ram[mem_addr[9:0]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  int ack_at, rel_at, rel_len;

  initial begin
    reset = 1'b1; cpu_addr = '0; cpu_we = 1'b0; cpu_wdata = '0; cpu_waiting = 1'b0;
    timeout_cfg = '0; host_req = 1'b0; host_we = 1'b0; host_addr = '0;
    host_wdata = '0; host_done = 1'b0;
    step(); step();
    reset = 1'b0;
    step();

    // Reset state
    check("rst_release", 32'(wait_release), 32'd0);
    check("rst_ack",     32'(host_ack),     32'd0);
    check("rst_rdata",   32'(host_rdata),   32'd0);
    check("rst_granted", 32'(host_granted), 32'd0);

    // CPU-only traffic, host request held pending
    cpu_addr = 18'h00100; cpu_we = 1'b1; cpu_wdata = 18'h2AAAA;
    host_req = 1'b1; host_we = 1'b1; host_addr = 18'h00020; host_wdata = 18'h3FFFF;
    #1;
    check("cpu_mem_addr", 32'(mem_addr), 32'h00100);
    check("cpu_mem_we",   32'(mem_we),   32'd1);
    check("cpu_mem_din",  32'(mem_din),  32'h2AAAA);
    for (int k = 0; k < 4; k++) begin
      step();
      check("cpu_no_ack", 32'(host_ack), 32'd0);
    end
    cpu_we = 1'b0;

    // Wait begins: pending host write to 0x20
    cpu_waiting = 1'b1;
    step();                                         // HOST_IDLE
    check("idle_granted", 32'(host_granted), 32'd1);
    check("idle_mem_we",  32'(mem_we),       32'd0);
    step();                                         // HOST_ACCESS
    check("acc_mem_addr", 32'(mem_addr), 32'h00020);
    check("acc_mem_we",   32'(mem_we),   32'd1);
    check("acc_mem_din",  32'(mem_din),  32'h3FFFF);
    step();                                         // ACK
    check("ack_not_yet",  32'(host_ack), 32'd0);
    step();                                         // HOST_IDLE, ack visible
    check("wr_ack_3cyc",  32'(host_ack), 32'd1);
    host_we = 1'b0;                                 // keep req high: read back 0x20
    step();
    check("ack_one_cycle", 32'(host_ack), 32'd0);
    step(); step();
    check("rd_ack",   32'(host_ack),   32'd1);
    check("rd_rdata", 32'(host_rdata), 32'h3FFFF);
    host_addr = 18'h00100;                          // read what the CPU wrote
    step(); step(); step();
    check("rd2_ack",   32'(host_ack),   32'd1);
    check("rd2_rdata", 32'(host_rdata), 32'h2AAAA);
    host_req = 1'b0;

    // host_done with timeout disabled
    host_done = 1'b1;
    step();
    check("done_release", 32'(wait_release), 32'd1);
    host_done = 1'b0; cpu_waiting = 1'b0; cpu_addr = 18'h00777;
    step();
    check("done_release_1cyc", 32'(wait_release), 32'd0);
    check("done_cpu_granted",  32'(host_granted), 32'd0);
    check("done_cpu_mux",      32'(mem_addr),     32'h00777);

    // Timeout with no host activity; cpu_waiting drops early (no effect)
    timeout_cfg = 16'd10; cpu_waiting = 1'b1;
    rel_at = -1; rel_len = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 1) cpu_waiting = 1'b0;
      if (wait_release) begin
        rel_len++;
        if (rel_at < 0) rel_at = k;
      end
    end
    check("tmo_release_at",  32'(rel_at),  32'd11);
    check("tmo_release_len", 32'(rel_len), 32'd1);

    // Timeout expires during an access: ack completes, then release
    timeout_cfg = 16'd2; cpu_waiting = 1'b1;
    host_req = 1'b1; host_we = 1'b0; host_addr = 18'h00020;
    ack_at = -1; rel_at = -1;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k == 1) cpu_waiting = 1'b0;
      if (host_ack && ack_at < 0) begin
        ack_at = k;
        host_req = 1'b0;
        check("tmo_acc_rdata", 32'(host_rdata), 32'h3FFFF);
      end
      if (wait_release && rel_at < 0) rel_at = k;
    end
    check("tmo_acc_ack_at", 32'(ack_at), 32'd4);
    check("tmo_acc_rel_at", 32'(rel_at), 32'd5);

    // host_done together with host_req: release wins, no ack
    timeout_cfg = '0; cpu_waiting = 1'b1;
    step();                                         // HOST_IDLE
    host_req = 1'b1; host_done = 1'b1; cpu_waiting = 1'b0;
    step();
    check("donereq_release", 32'(wait_release), 32'd1);
    check("donereq_no_ack",  32'(host_ack),     32'd0);
    host_req = 1'b0; host_done = 1'b0;
    step();
    check("donereq_no_ack2", 32'(host_ack),     32'd0);
    check("donereq_rel_end", 32'(wait_release), 32'd0);

    // Reset asserted during HOST_ACCESS
    cpu_waiting = 1'b1; host_req = 1'b1; host_we = 1'b1;
    host_addr = 18'h00030; host_wdata = 18'h01234; cpu_addr = 18'h00055;
    step();                                         // HOST_IDLE
    cpu_waiting = 1'b0;
    step();                                         // HOST_ACCESS
    check("rstacc_in_access", 32'(mem_addr), 32'h00030);
    reset = 1'b1;
    step();
    check("rstacc_ack",     32'(host_ack),     32'd0);
    check("rstacc_release", 32'(wait_release), 32'd0);
    check("rstacc_granted", 32'(host_granted), 32'd0);
    check("rstacc_rdata",   32'(host_rdata),   32'd0);
    check("rstacc_cpu_mux", 32'(mem_addr),     32'h00055);
    reset = 1'b0; host_req = 1'b0;
    step();
    check("rstacc_ack_after", 32'(host_ack), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wait_mem_arbiter.md
Name: wait_mem_arbiter

Overview:
- Shares the single data-memory port between processor stage 2 and an external host (loader/debugger/DMA).
- The CPU owns the port by default. The host is granted the port only while the CPU is stalled by OP_WAIT (waiting_global=1).
- The block ends the wait with a one-cycle release pulse, either when the host signals done or on timeout.
- Sits between stage 2 / host and the synchronous-read data RAM (read latency 1).

Parameters:
- ADDR_SIZE, 18, memory address width.
- WORD_SIZE, 18, data word width.
- TIMEOUT_BITS, 16, width of the wait timeout counter.

Ports:
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- cpu_addr  in  ADDR_SIZE  stage-2 memory address
- cpu_we  in  1  stage-2 write enable
- cpu_wdata  in  WORD_SIZE  stage-2 write data
- cpu_waiting  in  1  waiting_global from stage 2
- wait_release  out  1  one-cycle pulse; clears the stage-2 waiting flag
- timeout_cfg  in  TIMEOUT_BITS  wait timeout in cycles; 0 = no timeout
- host_req  in  1  host access request, held until host_ack
- host_we  in  1  1 = write, 0 = read
- host_addr  in  ADDR_SIZE  host address
- host_wdata  in  WORD_SIZE  host write data
- host_done  in  1  host session finished, release the CPU
- host_ack  out  1  one-cycle pulse; access complete, host_rdata valid
- host_rdata  out  WORD_SIZE  read data, registered
- host_granted  out  1  high in HOST_IDLE and HOST_ACCESS
- mem_addr  out  ADDR_SIZE  to RAM
- mem_we  out  1  to RAM
- mem_din  out  WORD_SIZE  to RAM
- mem_dout  in  WORD_SIZE  from RAM, valid one cycle after the address

Behaviour:
Reset values:
- State CPU.
- wait_release=0, host_ack=0, host_rdata=0, timeout counter=0.

Memory mux (combinational):
- In CPU and RELEASE states, mem_* = cpu_* with zero added latency, so stage 2 still sees same-cycle addressing.
- In HOST_IDLE, mem_we=0.
- In HOST_ACCESS, mem_* = host_*, with mem_we = host_we for exactly that one cycle.
- cpu_we is ignored in the host states. Stage 2 never writes while waiting.

State machine:
- CPU: if cpu_waiting=1, go to HOST_IDLE and clear the counter.
- HOST_IDLE, checked in priority order:
  1. host_done=1 goes to RELEASE.
  2. Timeout expiry goes to RELEASE.
  3. host_req=1 goes to HOST_ACCESS, with the host address presented in the next cycle.
- HOST_ACCESS: one cycle. Next cycle is ACK.
- ACK:
  - host_ack=1 and host_rdata <= mem_dout. Write data is don't-care for rdata; host_rdata still loads.
  - Next state is HOST_IDLE.
  - The host must drop host_req in the cycle after ack, or keep it high to request the next access. A new access is accepted from HOST_IDLE, so throughput is 1 access per 3 cycles.
- RELEASE: wait_release=1 for one cycle, then go to CPU.

Timeout:
- The counter increments every cycle outside CPU/RELEASE and saturates.
- Expiry = (timeout_cfg!=0 && counter >= timeout_cfg-1).
- Expiry during HOST_ACCESS/ACK is deferred: the ack completes, then RELEASE follows from HOST_IDLE.

Boundary cases:
- host_req while in CPU: not acked, held pending. Served once a wait begins.
- host_done together with host_req in HOST_IDLE: release wins, and the req is not acked.
- host_done asserted in HOST_ACCESS/ACK: ignored. The host re-asserts it in HOST_IDLE.
- cpu_waiting dropping while in a host state: no effect. The FSM still ends through RELEASE.
- Reset mid-access: no ack is issued and state returns to CPU.

Decomposition:
- Shared package: arbiter state enum (ARB_CPU, ARB_HOST_IDLE, ARB_HOST_ACCESS, ARB_ACK, ARB_RELEASE). OP_WAIT stays with the existing opcode constants.
- Sub-module: wait_timeout_counter (clear, enable, saturating count, cfg, expired output).

Test Plan:
- CPU-only traffic: cpu_addr=0x00100, cpu_we=1, wdata=0x2AAAA, with cpu_waiting=0 → mem_* mirror cpu_* the same cycle; host_req=1 is never acked.
- Wait then host write/read: cpu_waiting=1; host writes 0x3FFFF to 0x00020, then reads 0x00020 → each host_ack arrives 3 cycles after entering HOST_IDLE with host_req high; the read returns host_rdata=0x3FFFF.
- host_done with timeout_cfg=0 → wait_release pulses exactly 1 cycle, 1 cycle after host_done is sampled; the mux returns to CPU the next cycle.
- Timeout: timeout_cfg=10, no host activity → wait_release pulses 11 cycles after cpu_waiting rises (1 cycle to HOST_IDLE, 10 counting).
- Timeout during an access: timeout_cfg=2, host_req issued on the first HOST_IDLE cycle → the ack completes first, then wait_release pulses.
- host_done and host_req in the same cycle → no ack, release pulse. Separately, reset asserted in HOST_ACCESS → state CPU, host_ack=0, wait_release=0.
